dmem_copy_engine: RTL and testbench

Memory-side initiator for the single-cycle RISC-I data memory. On a start pulse it copies a block of 32-bit words from a source address range to a destination range in DataMEM, driving the MemRead/MemWrite/Address/Write_Data port that the CPU datapath normally drives, and reads back through Read_Data. It sits beside the datapath behind the DataMEM port mux and is used for memory initialisation and block moves during test and bring-up.

---
 rtl/dmem_copy_engine.sv | 151 +++++++++++++++
 tb/tb_dmem_copy_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: block copy initiator on the DataMEM port of the RISC-I datapath.
// Optional feature macro: DMEM_COPY_CHECKSUM_EN (adds o_Checksum, a running sum of words read).
// All outputs are registered: each is computed from the next state and loaded at the same edge.
module dmem_copy_engine #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_Start,
  input  logic [ADDR_W-1:0] i_Src_Addr,
  input  logic [ADDR_W-1:0] i_Dst_Addr,
  input  logic [ADDR_W:0]   i_Length,
  output logic              o_MemRead,
  output logic              o_MemWrite,
  output logic [ADDR_W-1:0] o_Address,
  output logic [DATA_W-1:0] o_Write_Data,
  input  logic [DATA_W-1:0] i_Read_Data,
  output logic              o_Busy,
`ifdef DMEM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0] o_Checksum,
`endif
  output logic              o_Done
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_src, r_dst, w_src_nxt, w_dst_nxt;
  logic [LEN_W-1:0]  r_len, r_k, w_len_nxt, w_k_nxt;
  logic [DATA_W-1:0] r_buf, w_buf_nxt;

  logic              r_mem_read, r_mem_write, r_busy, r_done;
  logic              w_mem_read_nxt, w_mem_write_nxt, w_busy_nxt, w_done_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;

  // State register
  always_ff @(posedge i_CLK) begin
    if (i_RST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, latched parameters, word index, buffer and next-cycle port values
  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src;
    w_dst_nxt       = r_dst;
    w_len_nxt       = r_len;
    w_k_nxt         = r_k;
    w_buf_nxt       = r_buf;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_addr_nxt      = '0;
    w_wdata_nxt     = '0;

    case (r_state)
      S_IDLE: begin
        if (i_Start) begin
          w_src_nxt   = i_Src_Addr;
          w_dst_nxt   = i_Dst_Addr;
          w_len_nxt   = (i_Length > MAX_LEN) ? MAX_LEN : i_Length;
          w_k_nxt     = '0;
          w_state_nxt = (w_len_nxt != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        w_buf_nxt   = i_Read_Data;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_k_nxt     = r_k + LEN_W'(1);
        w_state_nxt = (w_k_nxt == r_len) ? S_DONE : S_READ;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Port values for the cycle being entered; address wraps modulo 2^ADDR_W
    case (w_state_nxt)
      S_READ: begin
        w_mem_read_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
        w_addr_nxt     = w_src_nxt + w_k_nxt[ADDR_W-1:0];
      end
      S_WRITE: begin
        w_mem_write_nxt = 1'b1;
        w_busy_nxt      = 1'b1;
        w_addr_nxt      = w_dst_nxt + w_k_nxt[ADDR_W-1:0];
        w_wdata_nxt     = w_buf_nxt;
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: w_done_nxt = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_k         <= '0;
      r_buf       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_src       <= w_src_nxt;
      r_dst       <= w_dst_nxt;
      r_len       <= w_len_nxt;
      r_k         <= w_k_nxt;
      r_buf       <= w_buf_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
    end
  end

`ifdef DMEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] r_cks;

  // Checksum: cleared on accepted start, accumulates each word read, holds otherwise
  always_ff @(posedge i_CLK) begin
    if (i_RST)                           r_cks <= '0;
    else if (r_state == S_IDLE && i_Start) r_cks <= '0;
    else if (r_state == S_READ)          r_cks <= r_cks + i_Read_Data;
  end

  assign o_Checksum = r_cks;
`endif

  assign o_MemRead    = r_mem_read;
  assign o_MemWrite   = r_mem_write;
  assign o_Address    = r_addr;
  assign o_Write_Data = r_wdata;
  assign o_Busy       = r_busy;
  assign o_Done       = r_done;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Scoreboard bench for dmem_copy_engine: a word-level copy model predicts every memory
// access, its cycle and the completion pulse; a monitor compares them as the DUT emits them.
module tb_dmem_copy_engine;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int          DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] src, dst, addr;
  logic [AW:0]   len;
  logic          mem_read, mem_write, busy, done;
  logic [DW-1:0] wdata, rdata;
`ifdef DMEM_COPY_CHECKSUM_EN
  logic [DW-1:0] cks;
`endif

  dmem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_CLK(clk), .i_RST(rst), .i_Start(start),
    .i_Src_Addr(src), .i_Dst_Addr(dst), .i_Length(len),
    .o_MemRead(mem_read), .o_MemWrite(mem_write), .o_Address(addr),
    .o_Write_Data(wdata), .i_Read_Data(rdata), .o_Busy(busy),
`ifdef DMEM_COPY_CHECKSUM_EN
    .o_Checksum(cks),
`endif
    .o_Done(done)
  );

  always #5 clk = ~clk;

  // Behavioural DataMEM: combinational read, write on the rising edge; preload port for the bench
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] model [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_v;
  assign rdata = mem_read ? mem[addr] : '0;
  always @(posedge clk) begin
    if (mem_write)   mem[addr]  <= wdata;
    else if (pre_we) mem[pre_a] <= pre_v;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;   // 0 read, 1 write, 2 done
    int            cyc;
    int            addr;
    logic [DW-1:0] data;   // write data, or checksum for done
  } ev_t;
  ev_t sbq[$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT issues an access or a done pulse
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rw_exclusive", 64'(mem_read & mem_write), 0);
      chk("busy", 64'(busy), 64'(mem_read | mem_write));
      if (!mem_write) chk("wdata_zero", 64'(wdata), 0);
      if (mem_read || mem_write || done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          ev_t e;
          int  k;
          e = sbq.pop_front();
          k = mem_write ? 1 : (mem_read ? 0 : 2);
          chk("event_kind", 64'(k), 64'(e.kind));
          chk("event_cycle", 64'(cyc), 64'(e.cyc));
          if (e.kind < 2) chk("address", 64'(addr), 64'(e.addr));
          if (e.kind == 1) chk("write_data", 64'(wdata), 64'(e.data));
`ifdef DMEM_COPY_CHECKSUM_EN
          if (e.kind == 2) chk("checksum", 64'(cks), 64'(e.data));
`endif
        end
      end
    end
  end

  task automatic preload(input int a, input logic [DW-1:0] v);
    pre_we = 1'b1;
    pre_a  = AW'(a);
    pre_v  = v;
    model[a] = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic idle_sync();
    @(negedge clk);
    #2;
  endtask

  // One copy: predict accesses, drive start, optionally reset after rst_rel cycles or pulse start while busy
  task automatic run_copy(input int s, input int d, input int l, input int rst_rel, input bit busy_start);
    int t0, n, rabs, guard, diffs;
    logic [DW-1:0] sum, v;
    ev_t e;
    t0   = cyc + 1;
    n    = (l > DEPTH) ? DEPTH : l;
    rabs = (rst_rel > 0) ? t0 + rst_rel - 1 : 32'h7fffffff;
    sum  = '0;
    for (int k = 0; k < n; k++) begin
      if (t0 + 2*k > rabs) break;
      e.kind = 0; e.cyc = t0 + 2*k; e.addr = (s + k) % DEPTH; e.data = '0;
      v = model[e.addr];
      sum += v;
      sbq.push_back(e);
      if (t0 + 2*k + 1 > rabs) break;
      e.kind = 1; e.cyc = t0 + 2*k + 1; e.addr = (d + k) % DEPTH; e.data = v;
      model[e.addr] = v;
      sbq.push_back(e);
    end
    if (rst_rel <= 0) begin
      e.kind = 2; e.cyc = t0 + 2*n; e.addr = 0; e.data = sum;
      sbq.push_back(e);
    end

    start = 1'b1; src = AW'(s); dst = AW'(d); len = (AW+1)'(l);
    @(posedge clk);
    #1 start = 1'b0;
    src = AW'($urandom); dst = AW'($urandom); len = (AW+1)'($urandom);

    if (rst_rel > 0) begin
      while (cyc < rabs) idle_sync();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_memread", 64'(mem_read), 0);
      chk("rst_memwrite", 64'(mem_write), 0);
      chk("rst_address", 64'(addr), 0);
      chk("rst_wdata", 64'(wdata), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
`ifdef DMEM_COPY_CHECKSUM_EN
      chk("rst_checksum", 64'(cks), 0);
`endif
      #2;
    end

    if (busy_start) begin
      while (cyc < t0 + 2) idle_sync();
      start = 1'b1; src = AW'(s + 7); dst = AW'(d + 300); len = (AW+1)'(5);
      @(posedge clk);
      #1 start = 1'b0;
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 5000) begin
      idle_sync();
      guard++;
    end
    if (sbq.size() != 0) begin
      chk("completion_timeout", 64'(sbq.size()), 0);
      sbq.delete();
    end
    if (busy_start) begin
      // we are in the done cycle: a start here must be ignored too
      start = 1'b1; src = AW'(s); dst = AW'(d + 1); len = (AW+1)'(2);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) idle_sync();
    end
    idle_sync();
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== model[i]) diffs++;
    chk("mem_image", 64'(diffs), 0);
  endtask

  initial begin
    logic [DW-1:0] orig;
    int s, d, l;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    idle_sync();
    chk("reset_memread", 64'(mem_read), 0);
    chk("reset_memwrite", 64'(mem_write), 0);
    chk("reset_address", 64'(addr), 0);
    chk("reset_wdata", 64'(wdata), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
`ifdef DMEM_COPY_CHECKSUM_EN
    chk("reset_checksum", 64'(cks), 0);
`endif
    rst = 1'b0;
    idle_sync();
    mon_en = 1'b1;

    // basic copy
    preload(6, 1023); preload(7, 23); preload(8, 9);
    idle_sync();
    run_copy(6, 100, 3, 0, 1'b0);
    chk("basic_m100", 64'(mem[100]), 1023);
    chk("basic_m101", 64'(mem[101]), 23);
    chk("basic_m102", 64'(mem[102]), 9);

    // zero length
    run_copy(5, 9, 0, 0, 1'b0);

    // wrap-around with replication through the wrapped destination
    orig = mem[1022];
    run_copy(1022, 0, 4, 0, 1'b0);
    chk("wrap_m2", 64'(mem[2]), 64'(orig));

    // start while busy and in done
    run_copy(6, 100, 3, 0, 1'b1);

    // reset during the read of word 1: word 0 lands, word 1 never written
    preload(100, 32'hdead_beef); preload(101, 32'hcafe_f00d);
    idle_sync();
    run_copy(6, 100, 3, 3, 1'b0);
    chk("rst_m100", 64'(mem[100]), 1023);
    chk("rst_m101", 64'(mem[101]), 64'(32'hcafe_f00d));
    run_copy(6, 100, 3, 0, 1'b0);

    // forward overlap
    preload(10, 5); preload(11, 6);
    idle_sync();
    run_copy(10, 11, 2, 0, 1'b0);
    chk("ovl_m11", 64'(mem[11]), 5);
    chk("ovl_m12", 64'(mem[12]), 5);

    // src == dst, then an over-long length clamped to the full memory
    run_copy(200, 200, 5, 0, 1'b0);
    run_copy($urandom_range(0, 1023), $urandom_range(0, 1023), 2000, 0, 1'b0);

    // randomized copies, back to back
    for (int r = 0; r < 25; r++) begin
      s = $urandom_range(0, 1023);
      d = ($urandom_range(0, 3) == 0) ? (s + $urandom_range(0, 4)) % DEPTH : $urandom_range(0, 1023);
      l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      run_copy(s, d, l, ($urandom_range(0, 7) == 0 && l > 2) ? $urandom_range(1, 2*l) : 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not terminate");
  end

endmodule
